// File: rtl/riscv_multicycle_control_if.sv
// Bundle of control, strobe and debug signals between the multi-cycle control
// FSM (master) and the datapath/memories that it sequences (slave).
interface riscv_multicycle_control_if;
    logic [31:0] instruction;
    logic        Zero;
    logic        dmem_ack;
    logic        iMemRead;
    logic        MemRead;
    logic        MemWrite;
    logic        PCSrc;
    logic        ALUSrc;
    logic        RegWrite;
    logic        MemtoReg;
    logic        loadPC;
    logic [3:0]  ALUCtrl;
    logic        retire;
    logic [2:0]  state;
    logic        illegal;

    // Handshake: strobes (iMemRead, MemRead, MemWrite) are held high every cycle
    // until the slave completes; a data access completes in the cycle dmem_ack is
    // high while MemRead/MemWrite is high, and dmem_ack at any other time is ignored.
    modport master (
        input  instruction, Zero, dmem_ack,
        output iMemRead, MemRead, MemWrite, PCSrc, ALUSrc, RegWrite, MemtoReg,
               loadPC, ALUCtrl, retire, state, illegal
    );

    modport slave (
        output instruction, Zero, dmem_ack,
        input  iMemRead, MemRead, MemWrite, PCSrc, ALUSrc, RegWrite, MemtoReg,
               loadPC, ALUCtrl, retire, state, illegal
    );
endinterface

// File: rtl/riscv_multicycle_control.sv
// Multi-cycle control FSM for the simple RISC-V datapath.
// Sequences FETCH -> DECODE -> EXECUTE -> (MEM) -> (WRITEBACK) and decodes the
// datapath controls from the registered state and the current instruction.
// Optional feature macro: ILLEGAL_TRAP_EN (illegal instruction halts the core and
// sets the sticky illegal flag; otherwise an illegal instruction retires as a NOP).
module riscv_multicycle_control #(
    parameter bit USE_DMEM_ACK = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    riscv_multicycle_control_if.master    bus
);
    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEM       = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5
    } state_t;

    typedef enum logic [2:0] {C_ALU, C_LW, C_SW, C_BEQ, C_ILL} iclass_t;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_LT  = 4'b0111;
    localparam logic [3:0] ALU_SRL = 4'b1000;
    localparam logic [3:0] ALU_SLL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;
    localparam logic [3:0] ALU_XOR = 4'b1101;

    state_t      state_q, state_n;
    iclass_t     iclass;
    logic [3:0]  dec_alu;
    logic        dec_src;
    logic        illegal_n;
    logic        mem_done;
    logic        o_imem_read, o_mem_read, o_mem_write, o_pc_src, o_alu_src;
    logic        o_reg_write, o_mem_to_reg, o_load_pc;
    logic [3:0]  o_alu_ctrl;

    wire [6:0] opcode = bus.instruction[6:0];
    wire [2:0] funct3 = bus.instruction[14:12];
    wire [6:0] funct7 = bus.instruction[31:25];

    // Zero feeds the datapath PC mux directly; register/immediate fields are datapath-only.
    logic unused_bits;
    assign unused_bits = ^{bus.Zero, bus.instruction[24:15], bus.instruction[11:7]};

    // Data access completes on ack, or after a single cycle when ack is not used.
    assign mem_done = USE_DMEM_ACK ? bus.dmem_ack : 1'b1;

    // Instruction classification and ALU operation select.
    always_comb begin
        iclass  = C_ILL;
        dec_alu = ALU_ADD;
        dec_src = 1'b0;
        case (opcode)
            7'b0110011: begin
                if (funct7 == 7'b0000000) begin
                    iclass = C_ALU;
                    case (funct3)
                        3'd0: dec_alu = ALU_ADD;
                        3'd1: dec_alu = ALU_SLL;
                        3'd2: dec_alu = ALU_LT;
                        3'd4: dec_alu = ALU_XOR;
                        3'd5: dec_alu = ALU_SRL;
                        3'd6: dec_alu = ALU_OR;
                        3'd7: dec_alu = ALU_AND;
                        default: iclass = C_ILL;
                    endcase
                end else if (funct7 == 7'b0100000 && funct3 == 3'd0) begin
                    iclass  = C_ALU;
                    dec_alu = ALU_SUB;
                end else if (funct7 == 7'b0100000 && funct3 == 3'd5) begin
                    iclass  = C_ALU;
                    dec_alu = ALU_SRA;
                end
            end
            7'b0010011: begin
                dec_src = 1'b1;
                iclass  = C_ALU;
                case (funct3)
                    3'd0: dec_alu = ALU_ADD;
                    3'd2: dec_alu = ALU_LT;
                    3'd4: dec_alu = ALU_XOR;
                    3'd6: dec_alu = ALU_OR;
                    3'd7: dec_alu = ALU_AND;
                    3'd1: begin
                        dec_alu = ALU_SLL;
                        if (funct7 != 7'b0000000) iclass = C_ILL;
                    end
                    3'd5: begin
                        if (funct7 == 7'b0000000)      dec_alu = ALU_SRL;
                        else if (funct7 == 7'b0100000) dec_alu = ALU_SRA;
                        else                           iclass  = C_ILL;
                    end
                    default: iclass = C_ILL;
                endcase
            end
            7'b0000011: begin
                dec_src = 1'b1;
                if (funct3 == 3'b010) iclass = C_LW;
            end
            7'b0100011: begin
                dec_src = 1'b1;
                if (funct3 == 3'b010) iclass = C_SW;
            end
            7'b1100011: begin
                dec_alu = ALU_SUB;
                if (funct3 == 3'b000) iclass = C_BEQ;
            end
            default: iclass = C_ILL;
        endcase
    end

    // State register; reset aborts whatever instruction is in flight.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_n;
    end

    // Next-state and control outputs from the registered state, forced low in reset.
    always_comb begin
        state_n      = state_q;
        illegal_n    = 1'b0;
        o_imem_read  = 1'b0;
        o_mem_read   = 1'b0;
        o_mem_write  = 1'b0;
        o_pc_src     = 1'b0;
        o_alu_src    = 1'b0;
        o_reg_write  = 1'b0;
        o_mem_to_reg = 1'b0;
        o_load_pc    = 1'b0;
        o_alu_ctrl   = 4'b0000;
        case (state_q)
            S_FETCH: begin
                o_imem_read = 1'b1;
                state_n     = S_DECODE;
            end
            S_DECODE: begin
                if (iclass == C_ILL) begin
`ifdef ILLEGAL_TRAP_EN
                    state_n   = S_HALT;
                    illegal_n = 1'b1;
`else
                    state_n   = S_WRITEBACK;
`endif
                end else begin
                    state_n = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                o_alu_src  = dec_src;
                o_alu_ctrl = dec_alu;
                case (iclass)
                    C_LW, C_SW: state_n = S_MEM;
                    C_BEQ: begin
                        o_pc_src  = 1'b1;
                        o_load_pc = 1'b1;
                        state_n   = S_FETCH;
                    end
                    default: state_n = S_WRITEBACK;
                endcase
            end
            S_MEM: begin
                o_alu_src  = dec_src;
                o_alu_ctrl = dec_alu;
                if (iclass == C_LW) o_mem_read  = 1'b1;
                else                o_mem_write = 1'b1;
                if (mem_done) begin
                    if (iclass == C_LW) begin
                        state_n = S_WRITEBACK;
                    end else begin
                        o_load_pc = 1'b1;
                        state_n   = S_FETCH;
                    end
                end
            end
            S_WRITEBACK: begin
                o_alu_src    = dec_src;
                o_alu_ctrl   = dec_alu;
                o_reg_write  = (iclass != C_ILL);
                o_mem_to_reg = (iclass == C_LW);
                o_load_pc    = 1'b1;
                state_n      = S_FETCH;
            end
            S_HALT: state_n = S_HALT;
            default: state_n = S_FETCH;
        endcase
        if (rst) begin
            o_imem_read  = 1'b0;
            o_mem_read   = 1'b0;
            o_mem_write  = 1'b0;
            o_pc_src     = 1'b0;
            o_alu_src    = 1'b0;
            o_reg_write  = 1'b0;
            o_mem_to_reg = 1'b0;
            o_load_pc    = 1'b0;
            o_alu_ctrl   = 4'b0000;
        end
    end

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q;

    // Sticky illegal flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst)            illegal_q <= 1'b0;
        else if (illegal_n) illegal_q <= 1'b1;
    end

    assign bus.illegal = illegal_q & ~rst;
`else
    logic unused_illegal_n;
    assign unused_illegal_n = illegal_n;
    assign bus.illegal      = 1'b0;
`endif

    assign bus.iMemRead = o_imem_read;
    assign bus.MemRead  = o_mem_read;
    assign bus.MemWrite = o_mem_write;
    assign bus.PCSrc    = o_pc_src;
    assign bus.ALUSrc   = o_alu_src;
    assign bus.RegWrite = o_reg_write;
    assign bus.MemtoReg = o_mem_to_reg;
    assign bus.loadPC   = o_load_pc;
    assign bus.retire   = o_load_pc;
    assign bus.ALUCtrl  = o_alu_ctrl;
    assign bus.state    = state_q;
endmodule
